// File: rtl/sccb_init_seq_pkg.sv
// ============================================================================
// Module   : sccb_init_seq_pkg
// Purpose  : Shared SCCB command codes, delay marker and sequencer state encoding.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package sccb_init_seq_pkg;

    localparam logic [3:0] CMD_NONE  = 4'b0000;
    localparam logic [3:0] CMD_START = 4'b0001;
    localparam logic [3:0] CMD_WRITE = 4'b0010;
    localparam logic [3:0] CMD_READ  = 4'b0011;
    localparam logic [3:0] CMD_STOP  = 4'b0110;

    localparam logic [7:0] DLY_MARK = 8'hFF;
    localparam int         DLY_W    = 24;

    // Handshake phases inside every bus state
    localparam logic [1:0] SUB_ISSUE = 2'd0;
    localparam logic [1:0] SUB_GAP   = 2'd1;
    localparam logic [1:0] SUB_WAIT  = 2'd2;

    typedef enum logic [4:0] {
        ST_IDLE, ST_FETCH,
        ST_W_START, ST_W_ID, ST_W_REG, ST_W_VAL, ST_W_STOP,
        ST_DLY,
        ST_R_START, ST_R_ID, ST_R_REG, ST_R_STOP1,
        ST_R_START2, ST_R_ID2, ST_R_READ, ST_R_STOP2,
        ST_CHECK, ST_DONE, ST_ERROR
    } state_e;

endpackage

`default_nettype wire

// File: rtl/sccb_init_rom.sv
// ============================================================================
// Module   : sccb_init_rom
// Purpose  : Default camera init table (address / value / verify) by index.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sccb_init_rom
    import sccb_init_seq_pkg::*;
(
    input  logic [7:0] tbl_idx,
    output logic [7:0] tbl_addr,
    output logic [7:0] tbl_val,
    output logic       tbl_vfy
);

    logic [16:0] w_ent;

    always_comb begin
        w_ent = {DLY_MARK, 8'h00, 1'b0};
        case (tbl_idx)
            8'd0:  w_ent = {8'h12, 8'h80, 1'b0};   // soft reset, then settle
            8'd1:  w_ent = {DLY_MARK, 8'h0A, 1'b0};
            8'd2:  w_ent = {8'h11, 8'h01, 1'b1};
            8'd3:  w_ent = {8'h12, 8'h04, 1'b1};
            8'd4:  w_ent = {8'h0C, 8'h00, 1'b0};
            8'd5:  w_ent = {8'h3E, 8'h00, 1'b0};
            8'd6:  w_ent = {8'h40, 8'hD0, 1'b1};
            8'd7:  w_ent = {8'h8C, 8'h00, 1'b0};
            8'd8:  w_ent = {8'h3A, 8'h04, 1'b0};
            8'd9:  w_ent = {8'h14, 8'h18, 1'b0};
            8'd10: w_ent = {8'h4F, 8'hB3, 1'b0};
            8'd11: w_ent = {8'h50, 8'hB3, 1'b0};
            8'd12: w_ent = {8'h51, 8'h00, 1'b0};
            8'd13: w_ent = {8'h52, 8'h3D, 1'b0};
            8'd14: w_ent = {8'h53, 8'hA7, 1'b0};
            8'd15: w_ent = {8'h54, 8'hE4, 1'b0};
            8'd16: w_ent = {8'h58, 8'h9E, 1'b0};
            8'd17: w_ent = {8'h3D, 8'hC0, 1'b0};
            8'd18: w_ent = {8'h17, 8'h14, 1'b0};
            8'd19: w_ent = {8'h18, 8'h02, 1'b0};
            8'd20: w_ent = {8'h32, 8'h80, 1'b0};
            default: w_ent = {DLY_MARK, 8'h00, 1'b0};
        endcase
    end

    assign tbl_addr = w_ent[16:9];
    assign tbl_val  = w_ent[8:1];
    assign tbl_vfy  = w_ent[0];

endmodule

`default_nettype wire

// File: rtl/sccb_init_seq.sv
// ============================================================================
// Module   : sccb_init_seq
// Purpose  : Walks a register table, issuing SCCB writes, optional readback
//            verify with retry, and timed delay entries.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sccb_init_seq
    import sccb_init_seq_pkg::*;
#(
    parameter int          N_ENTRIES  = 21,
    parameter logic [7:0]  DEV_ID     = 8'h42,
    parameter int          DELAY_UNIT = 1000,
    parameter int          MAX_RETRY  = 3
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       start,
    output logic [7:0] tbl_idx,
    input  logic [7:0] tbl_addr,
    input  logic [7:0] tbl_val,
    input  logic       tbl_vfy,
    output logic       cmd_valid,
    output logic [3:0] cmd,
    output logic [7:0] cmd_dat,
    input  logic       busy,
    input  logic [7:0] rd_dat,
    output logic       active,
    output logic       done,
    output logic       error,
    output logic [7:0] err_idx
);

    localparam logic [7:0]       LAST_IDX  = 8'(N_ENTRIES - 1);
    localparam logic [7:0]       RETRY_LIM = 8'(MAX_RETRY);
    localparam logic [DLY_W-1:0] DLY_SAT   = '1;

    state_e           state_q, state_d;
    logic [1:0]       sub_q, sub_d;
    logic [7:0]       idx_q, idx_d;
    logic [7:0]       retry_q, retry_d;
    logic [7:0]       rd_q, rd_d;
    logic [DLY_W-1:0] cnt_q, cnt_d;
    logic             cmd_valid_q, cmd_valid_d;
    logic [3:0]       cmd_q, cmd_d;
    logic [7:0]       cmd_dat_q, cmd_dat_d;
    logic             active_q, active_d;
    logic             done_q, done_d;
    logic             error_q, error_d;
    logic [7:0]       err_idx_q, err_idx_d;

    logic             w_bus, w_bus_adv, w_adv;
    logic [3:0]       w_bus_cmd;
    logic [7:0]       w_bus_dat;
    state_e           w_bus_next;
    logic [39:0]      w_dly_prod;
    logic [DLY_W-1:0] w_dly_tgt;

    // Delay target clamps to the counter range so a saturated count still ends
    assign w_dly_prod = 40'(tbl_val) * 40'(DELAY_UNIT);
    assign w_dly_tgt  = (w_dly_prod > 40'(DLY_SAT)) ? DLY_SAT : w_dly_prod[DLY_W-1:0];

    always_comb begin
        state_d     = state_q;
        sub_d       = sub_q;
        idx_d       = idx_q;
        retry_d     = retry_q;
        rd_d        = rd_q;
        cnt_d       = cnt_q;
        cmd_valid_d = 1'b0;
        cmd_d       = CMD_NONE;
        cmd_dat_d   = 8'h00;
        active_d    = active_q;
        done_d      = done_q;
        error_d     = error_q;
        err_idx_d   = err_idx_q;
        w_bus       = 1'b1;
        w_bus_adv   = 1'b0;
        w_adv       = 1'b0;
        w_bus_cmd   = CMD_NONE;
        w_bus_dat   = 8'h00;
        w_bus_next  = ST_IDLE;

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                w_bus = 1'b0;
                if (start) begin
                    state_d   = ST_FETCH;
                    idx_d     = 8'd0;
                    retry_d   = 8'd0;
                    done_d    = 1'b0;
                    error_d   = 1'b0;
                    err_idx_d = 8'd0;
                    active_d  = 1'b1;
                end
            end
            ST_FETCH: begin
                w_bus   = 1'b0;
                cnt_d   = '0;
                state_d = (tbl_addr == DLY_MARK) ? ST_DLY : ST_W_START;
            end
            ST_W_START:  begin w_bus_cmd = CMD_START; w_bus_next = ST_W_ID; end
            ST_W_ID:     begin w_bus_cmd = CMD_WRITE; w_bus_dat = DEV_ID;   w_bus_next = ST_W_REG; end
            ST_W_REG:    begin w_bus_cmd = CMD_WRITE; w_bus_dat = tbl_addr; w_bus_next = ST_W_VAL; end
            ST_W_VAL:    begin w_bus_cmd = CMD_WRITE; w_bus_dat = tbl_val;  w_bus_next = ST_W_STOP; end
            ST_W_STOP: begin
                w_bus_cmd  = CMD_STOP;
                w_bus_next = ST_R_START;
                w_bus_adv  = !tbl_vfy;
            end
            ST_R_START:  begin w_bus_cmd = CMD_START; w_bus_next = ST_R_ID; end
            ST_R_ID:     begin w_bus_cmd = CMD_WRITE; w_bus_dat = DEV_ID;   w_bus_next = ST_R_REG; end
            ST_R_REG:    begin w_bus_cmd = CMD_WRITE; w_bus_dat = tbl_addr; w_bus_next = ST_R_STOP1; end
            ST_R_STOP1:  begin w_bus_cmd = CMD_STOP;  w_bus_next = ST_R_START2; end
            ST_R_START2: begin w_bus_cmd = CMD_START; w_bus_next = ST_R_ID2; end
            ST_R_ID2:    begin w_bus_cmd = CMD_WRITE; w_bus_dat = DEV_ID | 8'h01; w_bus_next = ST_R_READ; end
            ST_R_READ:   begin w_bus_cmd = CMD_READ;  w_bus_next = ST_R_STOP2; end
            ST_R_STOP2:  begin w_bus_cmd = CMD_STOP;  w_bus_next = ST_CHECK; end
            ST_DLY: begin
                w_bus = 1'b0;
                cnt_d = (cnt_q == DLY_SAT) ? cnt_q : cnt_q + 1'b1;
                if ({1'b0, cnt_q} + 25'd1 >= {1'b0, w_dly_tgt})
                    w_adv = 1'b1;
            end
            ST_CHECK: begin
                w_bus = 1'b0;
                if (rd_q == tbl_val) begin
                    w_adv = 1'b1;
                end else if (retry_q < RETRY_LIM) begin
                    retry_d = retry_q + 8'd1;
                    state_d = ST_W_START;
                end else begin
                    state_d   = ST_ERROR;
                    error_d   = 1'b1;
                    active_d  = 1'b0;
                    err_idx_d = idx_q;
                end
            end
            default: begin
                w_bus   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase

        // Common issue / gap / wait-for-idle handshake for every bus state
        if (w_bus) begin
            case (sub_q)
                SUB_ISSUE: begin
                    if (!busy) begin
                        cmd_valid_d = 1'b1;
                        cmd_d       = w_bus_cmd;
                        cmd_dat_d   = w_bus_dat;
                        sub_d       = SUB_GAP;
                    end
                end
                SUB_GAP: sub_d = SUB_WAIT;
                default: begin
                    if (!busy) begin
                        sub_d = SUB_ISSUE;
                        if (state_q == ST_R_READ)
                            rd_d = rd_dat;
                        if (w_bus_adv)
                            w_adv = 1'b1;
                        else
                            state_d = w_bus_next;
                    end
                end
            endcase
        end

        if (w_adv) begin
            retry_d = 8'd0;
            if (idx_q >= LAST_IDX) begin
                state_d  = ST_DONE;
                done_d   = 1'b1;
                active_d = 1'b0;
            end else begin
                idx_d   = idx_q + 8'd1;
                state_d = ST_FETCH;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            sub_q       <= SUB_ISSUE;
            idx_q       <= 8'd0;
            retry_q     <= 8'd0;
            rd_q        <= 8'd0;
            cnt_q       <= '0;
            cmd_valid_q <= 1'b0;
            cmd_q       <= CMD_NONE;
            cmd_dat_q   <= 8'd0;
            active_q    <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            err_idx_q   <= 8'd0;
        end else begin
            state_q     <= state_d;
            sub_q       <= sub_d;
            idx_q       <= idx_d;
            retry_q     <= retry_d;
            rd_q        <= rd_d;
            cnt_q       <= cnt_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_q       <= cmd_d;
            cmd_dat_q   <= cmd_dat_d;
            active_q    <= active_d;
            done_q      <= done_d;
            error_q     <= error_d;
            err_idx_q   <= err_idx_d;
        end
    end

    assign tbl_idx   = idx_q;
    assign cmd_valid = cmd_valid_q;
    assign cmd       = cmd_q;
    assign cmd_dat   = cmd_dat_q;
    assign active    = active_q;
    assign done      = done_q;
    assign error     = error_q;
    assign err_idx   = err_idx_q;

endmodule

`default_nettype wire

// File: doc/sccb_init_seq.md
SCCB_INIT_SEQ -- requirements
Module: sccb_init_seq

Interface
REQ-001 Parameter N_ENTRIES, default 21: number of register-table entries, 1..256.
REQ-002 Parameter DEV_ID, default 8'h42: SCCB write ID; the read ID is DEV_ID|1.
REQ-003 Parameter DELAY_UNIT, default 1000: clk_in cycles per delay-entry tick.
REQ-004 Parameter MAX_RETRY, default 3: retries per entry after a readback mismatch.
REQ-005 clk_in  in  1  system clock; all logic is on the rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 start  in  1  level or pulse that begins the sequence; sampled only in IDLE, DONE or ERROR.
REQ-008 tbl_idx  out  8  current table index.
REQ-009 tbl_addr  in  8  register address at tbl_idx; 8'hFF marks a delay entry.
REQ-010 tbl_val  in  8  register value at tbl_idx, or delay ticks for a delay entry.
REQ-011 tbl_vfy  in  1  readback-verify enable for the entry at tbl_idx.
REQ-012 cmd_valid  out  1  one-cycle command strobe to the SCCB master.
REQ-013 cmd  out  4  command code: START 4'b0001, WRITE 4'b0010, READ 4'b0011, STOP 4'b0110.
REQ-014 cmd_dat  out  8  write byte; valid with cmd_valid.
REQ-015 busy  in  1  SCCB master busy; asserted the cycle after an accepted cmd_valid and held until the command completes.
REQ-016 rd_dat  in  8  read byte; valid when busy falls after a READ.
REQ-017 active  out  1  high while the sequence runs.
REQ-018 done  out  1  high after all entries complete; held until the next start.
REQ-019 error  out  1  high after retries are exhausted; held until the next start.
REQ-020 err_idx  out  8  index of the failing entry; valid while error is high.

Function
REQ-021 FSM states: IDLE, FETCH, W_START, W_ID, W_REG, W_VAL, W_STOP, DLY, R_START, R_ID, R_REG, R_STOP1, R_START2, R_ID2, R_READ, R_STOP2, CHECK, DONE, ERROR.
REQ-022 Each bus state issues cmd_valid only when busy=0, then waits one cycle, then waits for busy=0 before advancing; no two strobes occur within 2 cycles of each other.
REQ-023 IDLE/DONE/ERROR with start=1: go to FETCH; tbl_idx=0, retry count=0; done=0, error=0, active=1.
REQ-024 FETCH lasts one cycle while table inputs settle; tbl_addr=8'hFF goes to DLY, otherwise to W_START.
REQ-025 Write phase order: START, WRITE DEV_ID, WRITE tbl_addr, WRITE tbl_val, STOP.
REQ-026 After W_STOP: if tbl_vfy=1 go to R_START, otherwise advance the entry.
REQ-027 Read phase order: START, WRITE DEV_ID, WRITE tbl_addr, STOP, START, WRITE DEV_ID|1, READ, STOP.
REQ-028 CHECK compares the captured rd_dat with tbl_val.
  - Equal: advance the entry.
  - Unequal with retry count < MAX_RETRY: increment the retry count and return to W_START.
  - Otherwise: go to ERROR with err_idx=tbl_idx.
REQ-029 DLY counts tbl_val*DELAY_UNIT cycles, then advances; tbl_val=0 advances after one cycle.
REQ-030 Advancing the entry clears the retry count. If tbl_idx=N_ENTRIES-1, go to DONE (done=1, active=0); otherwise increment tbl_idx and go to FETCH.
REQ-031 ERROR: error=1, active=0; no further commands are issued.
REQ-032 start while active is ignored.
REQ-033 The delay counter is 24 bits wide and saturates rather than wraps.
REQ-034 tbl_idx never exceeds N_ENTRIES-1.
REQ-035 MAX_RETRY=0 sends a mismatch straight to ERROR.

Reset
REQ-036 Reset forces the following immediately, including mid-transaction:
  - state=IDLE
  - cmd_valid=0, cmd=4'b0000, cmd_dat=0
  - tbl_idx=0, active=0, done=0, error=0, err_idx=0
  - all counters cleared.
REQ-037 No command is issued in the first cycle after reset release.

Structure
REQ-038 A shared package holds the command code constants, the delay marker 8'hFF, and the state encoding.
REQ-039 One sub-module, sccb_init_rom, provides the default camera table (tbl_addr, tbl_val, tbl_vfy indexed by tbl_idx) and sits outside the sequencer at integration level; the sequencer holds no table contents.

Verification
REQ-040 2-entry table {12:80, 11:01}, tbl_vfy=0, start pulse -> exactly 10 strobes in the order S,W42,W12,W80,P,S,W42,W11,W01,P; then done=1.
REQ-041 Entry {6B:0A}, tbl_vfy=1, model returns 0A -> 13 strobes ending S,W43,R,P; then done=1 with no retry.
REQ-042 Same entry, model always returns 00, MAX_RETRY=3 -> 4 write phases; then error=1, err_idx=0, done=0.
REQ-043 Entry {FF:03}, DELAY_UNIT=10 -> no strobes for 30 cycles; then the next entry starts.
REQ-044 Reset asserted mid-W_VAL -> the next cycle has all outputs at their reset values; a fresh start replays from index 0.
REQ-045 Second start during active -> no effect; start after done -> done=0 and the sequence reruns.
